// File: rtl/ifetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory req/gnt/rvalid channel plus the
// instr/pc/retire handshake with the single-cycle core.
interface ifetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        instr_valid;
   logic        retire;
   logic [31:0] pc_next;
   logic        halt;

   // Fetch unit side
   modport master (
      output imem_req, imem_addr,
      input  imem_gnt, imem_rvalid, imem_rdata,
      output instr, pc, instr_valid,
      input  retire, pc_next, halt
   );

   // Memory / core side
   modport slave (
      input  imem_req, imem_addr,
      output imem_gnt, imem_rvalid, imem_rdata,
      input  instr, pc, instr_valid,
      output retire, pc_next, halt
   );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch front-end: owns the architectural PC, fetches one word at
// a time over req/gnt/rvalid, presents it to the core and advances on retire.
// One request outstanding at a time; misaligned next PC or a missing rvalid
// parks the unit in a terminal ERROR state until reset.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
   input  logic                clk,
   input  logic                rst_n,
   ifetch_unit_if.master       bus,
   output logic                halted_o,
   output logic                fetch_err_o,
   output logic [31:0]         retire_cnt_o
);

   typedef enum logic [2:0] {
      S_REQ    = 3'd0,
      S_WAIT   = 3'd1,
      S_VALID  = 3'd2,
      S_HALTED = 3'd3,
      S_ERROR  = 3'd4
   } state_t;

   // Timeout is limited to 1..255, so an 8-bit wait counter suffices.
   localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic [31:0] retire_cnt_q, retire_cnt_d;
   logic        req_q, req_d;
   logic        valid_q, valid_d;
   logic        halted_q, halted_d;
   logic        err_q, err_d;

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      wait_cnt_d   = wait_cnt_q;
      retire_cnt_d = retire_cnt_q;

      case (state_q)
         S_REQ: begin
            // A grant only counts once the request is actually on the bus
            if (req_q && bus.imem_gnt) begin
               state_d    = S_WAIT;
               wait_cnt_d = 8'd0;
            end else begin
               state_d = S_REQ;
            end
         end
         S_WAIT: begin
            if (bus.imem_rvalid) begin
               instr_d = bus.imem_rdata;
               state_d = S_VALID;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
               if (wait_cnt_d == TIMEOUT_LIM) begin
                  state_d = S_ERROR;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_VALID: begin
            if (bus.retire) begin
               // PC always follows the core so a fault shows the bad target
               pc_d         = bus.pc_next;
               retire_cnt_d = retire_cnt_q + 32'd1;
               if (bus.pc_next[1:0] != 2'b00) begin
                  state_d = S_ERROR;
               end else if (bus.halt) begin
                  state_d = S_HALTED;
               end else begin
                  state_d = S_REQ;
               end
            end else begin
               state_d = S_VALID;
            end
         end
         S_HALTED: begin
            if (!bus.halt) begin
               state_d = S_REQ;
            end else begin
               state_d = S_HALTED;
            end
         end
         S_ERROR: begin
            state_d = S_ERROR;
         end
         default: begin
            state_d = S_ERROR;
         end
      endcase

      // Outputs are flopped from the state being entered
      req_d    = (state_d == S_REQ);
      valid_d  = (state_d == S_VALID);
      halted_d = (state_d == S_HALTED);
      err_d    = (state_d == S_ERROR);
   end

   // State and datapath registers, asynchronously reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC;
         instr_q      <= NOP_INSTR;
         wait_cnt_q   <= 8'd0;
         retire_cnt_q <= 32'd0;
         req_q        <= 1'b0;
         valid_q      <= 1'b0;
         halted_q     <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         wait_cnt_q   <= wait_cnt_d;
         retire_cnt_q <= retire_cnt_d;
         req_q        <= req_d;
         valid_q      <= valid_d;
         halted_q     <= halted_d;
         err_q        <= err_d;
      end
   end

   assign bus.imem_req    = req_q;
   assign bus.imem_addr   = pc_q;
   assign bus.instr       = instr_q;
   assign bus.pc          = pc_q;
   assign bus.instr_valid = valid_q;
   assign halted_o        = halted_q;
   assign fetch_err_o     = err_q;
   assign retire_cnt_o    = retire_cnt_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a per-cycle vector table for the fetch,
// stall, redirect and ignored-input cases, then hand-written sequences for
// halt/resume, reset during WAIT, rvalid timeout and misaligned next PC.
module tb_ifetch_unit;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        halted;
   logic        fetch_err;
   logic [31:0] retire_cnt;
   int          checks;
   int          errors;

   ifetch_unit_if bus_if ();

   ifetch_unit #(
      .RESET_PC       (32'h0000_0000),
      .TIMEOUT_CYCLES (16),
      .NOP_INSTR      (NOP)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus_if),
      .halted_o     (halted),
      .fetch_err_o  (fetch_err),
      .retire_cnt_o (retire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        gnt;
      logic        rv;
      logic [31:0] rdata;
      logic        ret;
      logic [31:0] pcn;
      logic        halt;
      logic        e_req;
      logic [31:0] e_pc;
      logic        e_valid;
      logic [31:0] e_instr;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t vecs[21];

   function automatic vec_t mk(logic gnt, logic rv, logic [31:0] rdata, logic ret,
                               logic [31:0] pcn, logic halt, logic e_req,
                               logic [31:0] e_pc, logic e_valid,
                               logic [31:0] e_instr, logic [31:0] e_cnt);
      vec_t v;
      v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.ret = ret; v.pcn = pcn;
      v.halt = halt; v.e_req = e_req; v.e_pc = e_pc; v.e_valid = e_valid;
      v.e_instr = e_instr; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic gnt, input logic rv, input logic [31:0] rdata,
                        input logic ret, input logic [31:0] pcn, input logic halt);
      bus_if.imem_gnt    = gnt;
      bus_if.imem_rvalid = rv;
      bus_if.imem_rdata  = rdata;
      bus_if.retire      = ret;
      bus_if.pc_next     = pcn;
      bus_if.halt        = halt;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_req"},    {31'd0, bus_if.imem_req},    32'd0);
      chk({tag, "_pc"},     bus_if.pc,                   32'd0);
      chk({tag, "_addr"},   bus_if.imem_addr,            32'd0);
      chk({tag, "_instr"},  bus_if.instr,                NOP);
      chk({tag, "_valid"},  {31'd0, bus_if.instr_valid}, 32'd0);
      chk({tag, "_halted"}, {31'd0, halted},             32'd0);
      chk({tag, "_err"},    {31'd0, fetch_err},          32'd0);
      chk({tag, "_rcnt"},   retire_cnt,                  32'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);

      // ---- vectors: zero-wait fetch, redirect to 0x40, 5-cycle gnt stall
      //            gnt  rv   rdata          ret  pcn            halt req  pc             vld  instr          rcnt
      vecs[0]  = mk(1'b0,1'b0,32'd0,        1'b0,32'd0,        1'b0,1'b0,32'h0000_0000,1'b0,NOP,          32'd0);
      vecs[1]  = mk(1'b1,1'b0,32'd0,        1'b0,32'd0,        1'b0,1'b1,32'h0000_0000,1'b0,NOP,          32'd0);
      vecs[2]  = mk(1'b0,1'b1,32'hA000_0000,1'b0,32'd0,        1'b0,1'b0,32'h0000_0000,1'b0,NOP,          32'd0);
      vecs[3]  = mk(1'b0,1'b0,32'd0,        1'b1,32'h0000_0004,1'b0,1'b0,32'h0000_0000,1'b1,32'hA000_0000,32'd0);
      vecs[4]  = mk(1'b1,1'b0,32'd0,        1'b0,32'd0,        1'b0,1'b1,32'h0000_0004,1'b0,32'hA000_0000,32'd1);
      vecs[5]  = mk(1'b0,1'b1,32'hA000_0004,1'b0,32'd0,        1'b0,1'b0,32'h0000_0004,1'b0,32'hA000_0000,32'd1);
      vecs[6]  = mk(1'b0,1'b0,32'd0,        1'b1,32'h0000_0008,1'b0,1'b0,32'h0000_0004,1'b1,32'hA000_0004,32'd1);
      vecs[7]  = mk(1'b1,1'b0,32'd0,        1'b0,32'd0,        1'b0,1'b1,32'h0000_0008,1'b0,32'hA000_0004,32'd2);
      vecs[8]  = mk(1'b0,1'b1,32'hA000_0008,1'b0,32'd0,        1'b0,1'b0,32'h0000_0008,1'b0,32'hA000_0004,32'd2);
      vecs[9]  = mk(1'b0,1'b0,32'd0,        1'b1,32'h0000_0040,1'b0,1'b0,32'h0000_0008,1'b1,32'hA000_0008,32'd2);
      vecs[10] = mk(1'b0,1'b0,32'd0,        1'b0,32'd0,        1'b0,1'b1,32'h0000_0040,1'b0,32'hA000_0008,32'd3);
      vecs[11] = mk(1'b0,1'b1,32'hBAD0_0001,1'b0,32'd0,        1'b0,1'b1,32'h0000_0040,1'b0,32'hA000_0008,32'd3);
      vecs[12] = mk(1'b0,1'b0,32'd0,        1'b1,32'h0000_0080,1'b0,1'b1,32'h0000_0040,1'b0,32'hA000_0008,32'd3);
      vecs[13] = mk(1'b0,1'b0,32'd0,        1'b0,32'd0,        1'b1,1'b1,32'h0000_0040,1'b0,32'hA000_0008,32'd3);
      vecs[14] = mk(1'b0,1'b0,32'd0,        1'b0,32'd0,        1'b0,1'b1,32'h0000_0040,1'b0,32'hA000_0008,32'd3);
      vecs[15] = mk(1'b1,1'b1,32'hDEAD_BEEF,1'b0,32'd0,        1'b0,1'b1,32'h0000_0040,1'b0,32'hA000_0008,32'd3);
      vecs[16] = mk(1'b0,1'b0,32'd0,        1'b1,32'h0000_0099,1'b0,1'b0,32'h0000_0040,1'b0,32'hA000_0008,32'd3);
      vecs[17] = mk(1'b0,1'b1,32'hB000_0040,1'b0,32'd0,        1'b0,1'b0,32'h0000_0040,1'b0,32'hA000_0008,32'd3);
      vecs[18] = mk(1'b0,1'b0,32'd0,        1'b0,32'd0,        1'b0,1'b0,32'h0000_0040,1'b1,32'hB000_0040,32'd3);
      vecs[19] = mk(1'b0,1'b0,32'd0,        1'b1,32'h0000_0044,1'b0,1'b0,32'h0000_0040,1'b1,32'hB000_0040,32'd3);
      vecs[20] = mk(1'b1,1'b0,32'd0,        1'b0,32'd0,        1'b0,1'b1,32'h0000_0044,1'b0,32'hB000_0040,32'd4);

      // ---- reset state
      step();
      step();
      chk_reset("rst0");
      rst_n = 1'b1;

      // ---- table
      for (int i = 0; i < 21; i++) begin
         drive(vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].ret, vecs[i].pcn, vecs[i].halt);
         chk($sformatf("v%0d_req", i),   {31'd0, bus_if.imem_req},    {31'd0, vecs[i].e_req});
         chk($sformatf("v%0d_addr", i),  bus_if.imem_addr,            vecs[i].e_pc);
         chk($sformatf("v%0d_pc", i),    bus_if.pc,                   vecs[i].e_pc);
         chk($sformatf("v%0d_valid", i), {31'd0, bus_if.instr_valid}, {31'd0, vecs[i].e_valid});
         chk($sformatf("v%0d_instr", i), bus_if.instr,                vecs[i].e_instr);
         chk($sformatf("v%0d_rcnt", i),  retire_cnt,                  vecs[i].e_cnt);
         chk($sformatf("v%0d_err", i),   {31'd0, fetch_err},          32'd0);
         chk($sformatf("v%0d_halted", i),{31'd0, halted},             32'd0);
         step();
      end

      // ---- halt / resume (in WAIT for 0x44 here)
      drive(1'b0, 1'b1, 32'hC000_0044, 1'b0, 32'd0, 1'b0);
      step();
      chk("h_valid44", {31'd0, bus_if.instr_valid}, 32'd1);
      chk("h_instr44", bus_if.instr, 32'hC000_0044);
      drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0010, 1'b0);
      step();
      chk("h_req10",  {31'd0, bus_if.imem_req}, 32'd1);
      chk("h_addr10", bus_if.imem_addr, 32'h0000_0010);
      chk("h_rcnt5",  retire_cnt, 32'd5);
      drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      step();
      drive(1'b0, 1'b1, 32'hC000_0010, 1'b0, 32'd0, 1'b0);
      step();
      chk("h_pc10", bus_if.pc, 32'h0000_0010);
      chk("h_valid10", {31'd0, bus_if.instr_valid}, 32'd1);
      drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0014, 1'b1);
      step();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
      chk("h_halted", {31'd0, halted}, 32'd1);
      chk("h_noreq",  {31'd0, bus_if.imem_req}, 32'd0);
      chk("h_novalid",{31'd0, bus_if.instr_valid}, 32'd0);
      chk("h_pc14",   bus_if.pc, 32'h0000_0014);
      chk("h_rcnt6",  retire_cnt, 32'd6);
      drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
      step();
      chk("h_hold", {31'd0, halted}, 32'd1);
      chk("h_hold_noreq", {31'd0, bus_if.imem_req}, 32'd0);
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      step();
      chk("h_resume_halted", {31'd0, halted}, 32'd0);
      chk("h_resume_req", {31'd0, bus_if.imem_req}, 32'd1);
      chk("h_resume_addr", bus_if.imem_addr, 32'h0000_0014);

      // ---- asynchronous reset while in WAIT, then late rvalid ignored
      drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      step();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      chk("w_inwait_req", {31'd0, bus_if.imem_req}, 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset("arst");
      step();
      rst_n = 1'b1;
      drive(1'b0, 1'b1, 32'hBAD0_0002, 1'b0, 32'd0, 1'b0);
      chk("late_req0", {31'd0, bus_if.imem_req}, 32'd0);
      step();
      chk("late_req1", {31'd0, bus_if.imem_req}, 32'd1);
      chk("late_instr", bus_if.instr, NOP);
      step();
      chk("late_valid", {31'd0, bus_if.instr_valid}, 32'd0);
      chk("late_instr2", bus_if.instr, NOP);

      // ---- rvalid timeout
      drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      step();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      for (int k = 0; k < 15; k++) step();
      chk("to_err_early", {31'd0, fetch_err}, 32'd0);
      step();
      chk("to_err", {31'd0, fetch_err}, 32'd1);
      chk("to_noreq", {31'd0, bus_if.imem_req}, 32'd0);
      drive(1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'd0, 1'b0);
      step();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      chk("to_late_instr", bus_if.instr, NOP);
      chk("to_late_valid", {31'd0, bus_if.instr_valid}, 32'd0);
      chk("to_sticky", {31'd0, fetch_err}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("to_rst_err", {31'd0, fetch_err}, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      chk("to_rst_req", {31'd0, bus_if.imem_req}, 32'd1);

      // ---- misaligned next PC
      drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      step();
      drive(1'b0, 1'b1, 32'hD000_0000, 1'b0, 32'd0, 1'b0);
      step();
      drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0042, 1'b0);
      step();
      drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      chk("mis_err", {31'd0, fetch_err}, 32'd1);
      chk("mis_pc", bus_if.pc, 32'h0000_0042);
      chk("mis_noreq", {31'd0, bus_if.imem_req}, 32'd0);
      chk("mis_novalid", {31'd0, bus_if.instr_valid}, 32'd0);
      chk("mis_rcnt", retire_cnt, 32'd1);
      step();
      step();
      chk("mis_sticky", {31'd0, fetch_err}, 32'd1);
      chk("mis_still_noreq", {31'd0, bus_if.imem_req}, 32'd0);
      chk("mis_pc_hold", bus_if.pc, 32'h0000_0042);
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk_reset("mis_rst");
      step();
      rst_n = 1'b1;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
